score_bitmap_gen: RTL

Holds the game score, converts it to BCD and produces the 32-bit 4x8 digit glyph bitmap that the score renderer latches on its frame strobe. It sits directly upstream of the score renderer, in place of the software-written bitmap path. Hit pulses from the tile logic update the score. Conversion runs once per frame on `animate`, so the glyph is stable while a frame is drawn.

---
 rtl/score_bitmap_gen_if.sv | 24 ++
 rtl/score_bitmap_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/score_bitmap_gen_if.sv
// Bus between the tile/frame control side and score_bitmap_gen.
// Slave is the generator. Master is whatever drives hits, frame strobes and
// digit selection, and reads back the score and glyph.
interface score_bitmap_gen_if;
  logic        hit;
  logic        clear;
  logic        animate;
  logic [1:0]  digit_sel;
  logic [9:0]  score;
  logic [11:0] bcd;
  logic [31:0] bitmap;
  logic        bitmap_valid;
  logic        busy;

  modport master (
    output hit, clear, animate, digit_sel,
    input  score, bcd, bitmap, bitmap_valid, busy
  );

  modport slave (
    input  hit, clear, animate, digit_sel,
    output score, bcd, bitmap, bitmap_valid, busy
  );
endinterface

// File: rtl/score_bitmap_gen.sv
// Score counter, per-frame binary-to-BCD conversion and 4x8 digit glyph
// generation for the score renderer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for animate or a pending request; glyph held
// S_CONVERT| double-dabble, one iteration per cycle, 10 cycles
// S_LOOKUP | register bcd, blank/select digit, register glyph, pulse valid
//
// An animate seen while not idle is remembered in pending_q, so a frame
// strobe is never lost. Any number of strobes during one conversion
// collapse into a single follow-up conversion.
module score_bitmap_gen #(
  parameter int unsigned MAX_SCORE = 999
) (
  input  logic               clk,
  input  logic               res,
  score_bitmap_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LOOKUP  = 2'd2
  } state_t;

  localparam logic [9:0] MAX_SCORE_W = 10'(MAX_SCORE);
  localparam logic [3:0] LAST_ITER   = 4'd9;

  state_t      state_q, state_d;
  logic [9:0]  score_q, score_d;
  logic [21:0] sr_q, sr_d;
  logic [3:0]  iter_q, iter_d;
  logic [1:0]  sel_q, sel_d;
  logic        pending_q, pending_d;
  logic [11:0] bcd_q, bcd_d;
  logic [31:0] bitmap_q, bitmap_d;
  logic        valid_q, valid_d;

  logic [3:0]  digit_nib;
  logic        digit_blank;

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [21:0] dd_step(input logic [21:0] sr);
    logic [21:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[10 + 4*i +: 4] >= 4'd5) begin
        t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[20:0], 1'b0};
  endfunction

  // 4x8 glyphs, bit index = 4*row + col, row 0 at the top.
  function automatic logic [31:0] glyph(input logic [3:0] d);
    logic [31:0] g;
    case (d)
      4'd0:    g = 32'h69999996;
      4'd1:    g = 32'hE4444464;
      4'd2:    g = 32'hF1124896;
      4'd3:    g = 32'h69886896;
      4'd4:    g = 32'h8888F999;
      4'd5:    g = 32'h6988711F;
      4'd6:    g = 32'h69997116;
      4'd7:    g = 32'h2224488F;
      4'd8:    g = 32'h69996996;
      4'd9:    g = 32'h688E9996;
      default: g = 32'h00000000;
    endcase
    return g;
  endfunction

  // Score counter: clear wins over hit, hit saturates at MAX_SCORE.
  always_comb begin
    score_d = score_q;
    if (bus.clear) begin
      score_d = '0;
    end else if (bus.hit && (score_q < MAX_SCORE_W)) begin
      score_d = score_q + 10'd1;
    end
  end

  // Pick the snapped digit from the freshly converted BCD and decide blanking.
  always_comb begin
    digit_nib   = 4'd0;
    digit_blank = 1'b1;
    case (sel_q)
      2'd0: begin
        digit_nib   = sr_q[13:10];
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_nib   = sr_q[17:14];
        digit_blank = (sr_q[17:14] == 4'd0) && (sr_q[21:18] == 4'd0);
      end
      2'd2: begin
        digit_nib   = sr_q[21:18];
        digit_blank = (sr_q[21:18] == 4'd0);
      end
      default: begin
        digit_nib   = 4'd0;
        digit_blank = 1'b1;
      end
    endcase
  end

  // FSM next state, conversion datapath and output register updates.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    iter_d    = iter_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    bcd_d     = bcd_q;
    bitmap_d  = bitmap_q;
    valid_d   = 1'b0;

    if (bus.animate && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.animate || pending_q) begin
          sr_d      = {12'b0, score_q};
          sel_d     = bus.digit_sel;
          iter_d    = 4'd0;
          pending_d = 1'b0;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        sr_d   = dd_step(sr_q);
        iter_d = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        bcd_d    = sr_q[21:10];
        bitmap_d = digit_blank ? 32'h00000000 : glyph(digit_nib);
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_IDLE;
      score_q   <= '0;
      sr_q      <= '0;
      iter_q    <= '0;
      sel_q     <= '0;
      pending_q <= 1'b0;
      bcd_q     <= '0;
      bitmap_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      sr_q      <= sr_d;
      iter_q    <= iter_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      bitmap_q  <= bitmap_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.score        = score_q;
  assign bus.bcd          = bcd_q;
  assign bus.bitmap       = bitmap_q;
  assign bus.bitmap_valid = valid_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule
